// File: rtl/rename_maptable_pkg.sv
// -----------------------------------------------------------------------------
// rename_maptable_pkg
// Shared definitions for the speculative rename map table.
//   PR_W       : physical register tag width, taken from the global `PR macro
//   DISPATCH_W : rename/dispatch group width (3 ways)
//   AR_N       : number of architectural registers
//   MT_ENTRY   : one map table entry {pr, ready}
//   cdb_match  : true when a PR matches any valid CDB tag this cycle
// -----------------------------------------------------------------------------
`ifndef PR
`define PR 6
`endif

package rename_maptable_pkg;

  localparam int DISPATCH_W = 3;
  localparam int PR_W       = `PR;
  localparam int AR_N       = 32;

  typedef struct packed {
    logic [PR_W-1:0] pr;
    logic            ready;
  } MT_ENTRY;

  // OR-reduce of per-lane tag compares against a single physical register
  function automatic logic cdb_match(
    input logic [DISPATCH_W-1:0]           valid,
    input logic [DISPATCH_W-1:0][PR_W-1:0] tag,
    input logic [PR_W-1:0]                 pr
  );
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < DISPATCH_W; c++) begin
      hit = hit | (valid[c] & (tag[c] == pr));
    end
    return hit;
  endfunction

endpackage

// File: rtl/rename_dep_check.sv
// -----------------------------------------------------------------------------
// rename_dep_check
// In-group dependency check for one lookup field (rs1, rs2 or told).
// For each way w it finds the nearest older way (higher index) that has an
// effective destination write to the queried AR.
//   write_en : per-way effective write (already excludes AR 0)
//   dest_ar  : per-way destination AR
//   dest_pr  : per-way newly allocated PR
//   query_ar : per-way AR being looked up
//   hit      : an older way in the group writes query_ar
//   fwd_pr   : that older way's dest_pr (zero when no hit)
// -----------------------------------------------------------------------------
module rename_dep_check
  import rename_maptable_pkg::*;
(
  input  logic [DISPATCH_W-1:0]           write_en,
  input  logic [DISPATCH_W-1:0][4:0]      dest_ar,
  input  logic [DISPATCH_W-1:0][PR_W-1:0] dest_pr,
  input  logic [DISPATCH_W-1:0][4:0]      query_ar,
  output logic [DISPATCH_W-1:0]           hit,
  output logic [DISPATCH_W-1:0][PR_W-1:0] fwd_pr
);

  // Older ways are scanned oldest-first so the nearest older match lands last
  always_comb begin
    hit    = '0;
    fwd_pr = '0;
    for (int w = 0; w < DISPATCH_W; w++) begin
      for (int o = DISPATCH_W - 1; o > w; o--) begin
        hit[w]    = hit[w] | (write_en[o] & (dest_ar[o] == query_ar[w]));
        fwd_pr[w] = (write_en[o] && (dest_ar[o] == query_ar[w])) ? dest_pr[o] : fwd_pr[w];
      end
    end
  end

endmodule

// File: rtl/rename_maptable.sv
// -----------------------------------------------------------------------------
// rename_maptable
// Speculative AR->PR map table with per-entry ready bits for a 3-way rename
// group. Provides renamed sources with ready status and the previous mapping
// (Told) of each destination, absorbs CDB completions and restores from the
// retire-stage architectural map on branch recovery.
// Optional feature: define MAPTABLE_CDB_BYPASS_EN to let table-sourced ready
// bits see same-cycle CDB tags.
// Ports:
//   clock, reset (sync, active-low)
//   dispatch_en/dest_valid/dest_ar/dest_pr : per-way dispatch writes
//   rs1_ar/rs2_ar -> rs1_pr/rs2_pr, rs1_ready/rs2_ready : source lookups
//   told_out         : prior mapping of each way's dest_ar
//   cdb_valid/cdb_tag: completing PRs
//   BPRecoverEN/recover_maptable : branch recovery restore
//   maptable_display/ready_display : registered table state
// -----------------------------------------------------------------------------
module rename_maptable
  import rename_maptable_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DISPATCH_W-1:0]           dispatch_en,
  input  logic [DISPATCH_W-1:0]           dest_valid,
  input  logic [DISPATCH_W-1:0][4:0]      dest_ar,
  input  logic [DISPATCH_W-1:0][PR_W-1:0] dest_pr,
  input  logic [DISPATCH_W-1:0][4:0]      rs1_ar,
  input  logic [DISPATCH_W-1:0][4:0]      rs2_ar,
  output logic [DISPATCH_W-1:0][PR_W-1:0] rs1_pr,
  output logic [DISPATCH_W-1:0][PR_W-1:0] rs2_pr,
  output logic [DISPATCH_W-1:0]           rs1_ready,
  output logic [DISPATCH_W-1:0]           rs2_ready,
  output logic [DISPATCH_W-1:0][PR_W-1:0] told_out,
  input  logic [DISPATCH_W-1:0]           cdb_valid,
  input  logic [DISPATCH_W-1:0][PR_W-1:0] cdb_tag,
  input  logic                            BPRecoverEN,
  input  logic [AR_N-1:0][PR_W-1:0]       recover_maptable,
  output logic [AR_N-1:0][PR_W-1:0]       maptable_display,
  output logic [AR_N-1:0]                 ready_display
);

  MT_ENTRY table_r    [AR_N];
  MT_ENTRY table_next [AR_N];

  logic [DISPATCH_W-1:0]           wr_en;
  logic [DISPATCH_W-1:0]           rs1_hit, rs2_hit, told_hit;
  logic [DISPATCH_W-1:0][PR_W-1:0] rs1_fwd, rs2_fwd, told_fwd;

  // Effective writes: AR 0 is hard-wired and never written
  always_comb begin
    for (int w = 0; w < DISPATCH_W; w++) begin
      wr_en[w] = dispatch_en[w] & dest_valid[w] & (dest_ar[w] != 5'd0);
    end
  end

  rename_dep_check u_dep_rs1 (
    .write_en (wr_en),
    .dest_ar  (dest_ar),
    .dest_pr  (dest_pr),
    .query_ar (rs1_ar),
    .hit      (rs1_hit),
    .fwd_pr   (rs1_fwd)
  );

  rename_dep_check u_dep_rs2 (
    .write_en (wr_en),
    .dest_ar  (dest_ar),
    .dest_pr  (dest_pr),
    .query_ar (rs2_ar),
    .hit      (rs2_hit),
    .fwd_pr   (rs2_fwd)
  );

  rename_dep_check u_dep_told (
    .write_en (wr_en),
    .dest_ar  (dest_ar),
    .dest_pr  (dest_pr),
    .query_ar (dest_ar),
    .hit      (told_hit),
    .fwd_pr   (told_fwd)
  );

  // Rename lookups: in-group forwarding first, then the registered table
  always_comb begin
    for (int w = 0; w < DISPATCH_W; w++) begin
      rs1_pr[w] = rs1_hit[w] ? rs1_fwd[w] : table_r[rs1_ar[w]].pr;
      rs2_pr[w] = rs2_hit[w] ? rs2_fwd[w] : table_r[rs2_ar[w]].pr;
`ifdef MAPTABLE_CDB_BYPASS_EN
      rs1_ready[w] = rs1_hit[w] ? 1'b0 :
                     (table_r[rs1_ar[w]].ready | cdb_match(cdb_valid, cdb_tag, table_r[rs1_ar[w]].pr));
      rs2_ready[w] = rs2_hit[w] ? 1'b0 :
                     (table_r[rs2_ar[w]].ready | cdb_match(cdb_valid, cdb_tag, table_r[rs2_ar[w]].pr));
`else
      rs1_ready[w] = rs1_hit[w] ? 1'b0 : table_r[rs1_ar[w]].ready;
      rs2_ready[w] = rs2_hit[w] ? 1'b0 : table_r[rs2_ar[w]].ready;
`endif
      told_out[w]  = told_hit[w] ? told_fwd[w] :
                     ((dest_ar[w] == 5'd0) ? '0 : table_r[dest_ar[w]].pr);
    end
  end

  // Next-state: recovery overrides everything; else CDB, then dispatch on top
  always_comb begin
    for (int i = 0; i < AR_N; i++) begin
      table_next[i] = table_r[i];
    end
    if (BPRecoverEN) begin
      for (int i = 0; i < AR_N; i++) begin
        table_next[i].pr    = (i == 0) ? '0 : recover_maptable[i];
        table_next[i].ready = 1'b1;
      end
    end else begin
      for (int i = 0; i < AR_N; i++) begin
        table_next[i].ready = table_r[i].ready | cdb_match(cdb_valid, cdb_tag, table_r[i].pr);
        // oldest to youngest so the youngest writer of an AR wins
        for (int w = DISPATCH_W - 1; w >= 0; w--) begin
          table_next[i].pr    = (wr_en[w] && (dest_ar[w] == 5'(i))) ? dest_pr[w] : table_next[i].pr;
          table_next[i].ready = (wr_en[w] && (dest_ar[w] == 5'(i))) ? 1'b0       : table_next[i].ready;
        end
      end
    end
  end

  // Table register with synchronous active-low reset to the identity map
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < AR_N; i++) begin
        table_r[i] <= '{pr: PR_W'(i), ready: 1'b1};
      end
    end else begin
      for (int i = 0; i < AR_N; i++) begin
        table_r[i] <= table_next[i];
      end
    end
  end

  // Display outputs are straight views of the registered table
  always_comb begin
    for (int i = 0; i < AR_N; i++) begin
      maptable_display[i] = table_r[i].pr;
      ready_display[i]    = table_r[i].ready;
    end
  end

endmodule
